// File: rtl/multiplier_ctrl_pkg.sv
// Shared definitions for the multiplier sequencing controller:
// FSM state encoding, default datapath latency and HI/LO register width.
package multiplier_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_LATENCY = 5;
    localparam int HILO_W      = 32;

endpackage

// File: rtl/multiplier_ctrl_hilo_regs.sv
// HI/LO architectural registers. A product capture loads both halves and
// takes priority over mthi/mtlo writes presented in the same cycle.
module hilo_regs
    import multiplier_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_cap_en,
    input  logic [2*HILO_W-1:0]   i_cap_data,
    input  logic                  i_wr_hi,
    input  logic                  i_wr_lo,
    input  logic [HILO_W-1:0]     i_wdata,
    output logic [HILO_W-1:0]     o_hi,
    output logic [HILO_W-1:0]     o_lo
);

    logic [HILO_W-1:0] r_hi;
    logic [HILO_W-1:0] r_lo;

    // HI/LO update: capture first, otherwise independent move writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= {HILO_W{1'b0}};
            r_lo <= {HILO_W{1'b0}};
        end else if (i_cap_en) begin
            r_hi <= i_cap_data[2*HILO_W-1:HILO_W];
            r_lo <= i_cap_data[HILO_W-1:0];
        end else begin
            if (i_wr_hi) begin
                r_hi <= i_wdata;
            end
            if (i_wr_lo) begin
                r_lo <= i_wdata;
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/multiplier_ctrl.sv
// Sequencing controller for the signed 32x32 multiplier datapath: latches and
// holds operands, counts latency, captures the product and stalls on HI/LO hazards.
module multiplier_ctrl
    import multiplier_ctrl_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int CNT_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [HILO_W-1:0]     req_in1,
    input  logic [HILO_W-1:0]     req_in2,
    input  logic                  cancel,
    input  logic                  mfhi,
    input  logic                  mflo,
    input  logic                  mthi,
    input  logic                  mtlo,
    input  logic [HILO_W-1:0]     wdata,
    output logic [HILO_W-1:0]     hi_out,
    output logic [HILO_W-1:0]     lo_out,
    output logic                  stall,
    output logic                  done,
    output logic [HILO_W-1:0]     mul_in1,
    output logic [HILO_W-1:0]     mul_in2,
    input  logic [2*HILO_W-1:0]   mul_out
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [HILO_W-1:0]  r_op1;
    logic [HILO_W-1:0]  r_op2;
    logic               r_done;

    logic               w_capture;
    logic               w_idle;
    logic               w_wr_hi;
    logic               w_wr_lo;

    assign w_idle    = (r_state == IDLE);
    // cancel on the final RUN cycle still abandons the result
    assign w_capture = (r_state == RUN) && !cancel && (r_count == LAST_CNT);
    assign w_wr_hi   = mthi && w_idle;
    assign w_wr_lo   = mtlo && w_idle;

    // Operation FSM with latency counter, operand hold and done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_count <= {CNT_W{1'b0}};
            r_op1   <= {HILO_W{1'b0}};
            r_op2   <= {HILO_W{1'b0}};
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid && !cancel) begin
                        r_state <= RUN;
                        r_op1   <= req_in1;
                        r_op2   <= req_in2;
                        r_count <= {CNT_W{1'b0}};
                    end
                end
                RUN: begin
                    if (cancel) begin
                        r_state <= IDLE;
                    end else if (r_count == LAST_CNT) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    hilo_regs u_hilo_regs (
        .clk        (clk),
        .rst_n      (reset),
        .i_cap_en   (w_capture),
        .i_cap_data (mul_out),
        .i_wr_hi    (w_wr_hi),
        .i_wr_lo    (w_wr_lo),
        .i_wdata    (wdata),
        .o_hi       (hi_out),
        .o_lo       (lo_out)
    );

    assign req_ready = w_idle;
    assign stall     = (mfhi || mflo || mthi || mtlo) && !w_idle;
    assign done      = r_done;
    assign mul_in1   = r_op1;
    assign mul_in2   = r_op2;

endmodule
